data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256: number of 32-bit words stored; power of two, at least 4.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2: wait states inserted before each response; range 0-15.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port address, input, 32 bits: byte address from the processor.
REQ-006 SHALL have port write_data, input, 32 bits: store data.
REQ-007 SHALL have port mem_read, input, 1 bit: load request.
REQ-008 SHALL have port mem_write, input, 1 bit: store request.
REQ-009 SHALL have port ram_data, output, 32 bits: registered load data returned to the processor.
REQ-010 SHALL have port ready, output, 1 bit: one-cycle pulse marking request completion.
REQ-011 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-012 SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-013 SHALL, in IDLE with mem_read or mem_write high, latch address, write_data and the request type; load the counter with WAIT_CYCLES; go to WAIT, or go directly to RESP when WAIT_CYCLES=0.
REQ-014 SHALL, in WAIT, decrement the counter each cycle and go to RESP in the cycle after the counter reads 1.
REQ-015 SHALL perform the access in RESP using the latched values: a store writes the word; a load registers the word into ram_data. ready=1 for exactly that one cycle, then the FSM returns to IDLE.
REQ-016 SHALL give a latency of WAIT_CYCLES+1 cycles from the request-sampling edge to ready high.
REQ-017 SHALL ignore mem_read and mem_write while in WAIT or RESP; the initiator holds its request until ready.
REQ-018 SHALL treat mem_read and mem_write both high as a store; ram_data returns the word's contents before the write.
REQ-019 SHALL form the word index from address[log2(DEPTH)+1:2]; address[1:0] is ignored.
REQ-020 SHALL hold ram_data at the last load value until the next load completes; a store does not change ram_data, except as stated in REQ-018.
REQ-021 SHALL allow a new request to be sampled in the IDLE cycle immediately after ready, giving back-to-back throughput of one access per WAIT_CYCLES+2 cycles.

Reset
REQ-022 SHALL, with rst high at a clock edge, force the FSM to IDLE, counter=0, ready=0, busy=0 and ram_data=32'h0000_0000.
REQ-023 SHALL abort any access in progress on reset mid-operation; an aborted store does not modify memory.
REQ-024 SHALL leave memory array contents unchanged by reset; the array is zero-initialised at time 0 only.

Configuration
REQ-025 SHALL support the macro DMEM_RANGE_CHECK_EN.
REQ-026 SHALL, with DMEM_RANGE_CHECK_EN defined, add output port err, 1 bit, reset 0.
REQ-027 SHALL, with DMEM_RANGE_CHECK_EN defined, flag an access as a fault when address >= DEPTH*4 or address[1:0] != 0. A fault suppresses any write, drives ram_data=32'hDEAD_BEEF and raises err together with ready for the same single cycle.
REQ-028 SHALL, without DMEM_RANGE_CHECK_EN, have no err port and wrap out-of-range addresses modulo DEPTH words.

Verification
REQ-029 SHALL verify store-then-load with WAIT_CYCLES=2: store 32'h1234_5678 at 0x10, then load 0x10 -> ready 3 cycles after each request; ram_data=32'h1234_5678.
REQ-030 SHALL verify zero wait with WAIT_CYCLES=0: load 0x0 after reset -> ready on the next cycle; ram_data=0.
REQ-031 SHALL verify simultaneous requests: mem_read=mem_write=1, write_data=32'hAAAA_5555 at 0x20 holding 32'h1 -> ram_data=32'h1; a later load of 0x20 returns 32'hAAAA_5555.
REQ-032 SHALL verify reset mid-operation: assert rst during WAIT of a store of 32'hFFFF_FFFF to 0x8 -> ready never pulses; a later load of 0x8 returns the old value.
REQ-033 SHALL verify range check with DEPTH=256: with DMEM_RANGE_CHECK_EN defined, store to 0x400 -> err=1, ram_data=32'hDEAD_BEEF, word 0 unchanged; without the macro, the same store writes word 0.

Source files
------------

// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
//
// Word-organised data memory answering processor load/store requests after a
// fixed number of wait states. A request is sampled in IDLE, waits
// WAIT_CYCLES cycles in WAIT, then completes in RESP where ready pulses for
// one cycle. Loads are registered into ram_data on entry to RESP so the data
// is valid while ready is high. Stores commit on the edge that leaves RESP,
// so a reset at any point before completion discards the store.
//
// Optional feature: define DMEM_RANGE_CHECK_EN to add the err output and
// fault detection for out-of-range or misaligned addresses.
//
// Parameters:
//   DEPTH        number of 32-bit words (power of two, >= 4)
//   WAIT_CYCLES  wait states before each response (0..15)
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   address      byte address
//   write_data   store data
//   mem_read     load request
//   mem_write    store request (wins over mem_read when both are high)
//   ram_data     registered load data
//   ready        one-cycle completion pulse
//   busy         high whenever the FSM is not idle
//   err          (DMEM_RANGE_CHECK_EN only) fault flag, valid with ready
// ----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] ram_data,
    output logic        ready,
    output logic        busy
`ifdef DMEM_RANGE_CHECK_EN
    ,
    output logic        err
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e        r_state;
    state_e        w_state_next;
    logic [3:0]    r_count;
    logic [3:0]    w_count_next;
    logic          w_enter_resp;

    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic          r_read;
    logic          r_write;
    logic          r_err;
    logic [31:0]   r_ram_data;

    // Zero at time 0 only; reset never touches the array.
    logic [31:0]   r_mem [DEPTH] = '{default: '0};

    logic          w_sel_read;
    logic [31:0]   w_sel_addr;
    logic [AW-1:0] w_sel_idx;
    logic [AW-1:0] w_resp_idx;
    logic          w_fault;
    logic          w_req;

    assign w_req = mem_read | mem_write;

    // With WAIT_CYCLES=0 the access starts on the sampling edge itself, so the
    // live port values must be used instead of the not-yet-latched copies.
    assign w_sel_read = (r_state == StIdle) ? mem_read : r_read;
    assign w_sel_addr = (r_state == StIdle) ? address  : r_addr;
    assign w_sel_idx  = w_sel_addr[AW+1:2];
    assign w_resp_idx = r_addr[AW+1:2];

`ifdef DMEM_RANGE_CHECK_EN
    assign w_fault = ((w_sel_addr >> (AW + 2)) != 32'd0) || (w_sel_addr[1:0] != 2'b00);
`else
    // Out-of-range addresses wrap: upper and byte-offset bits are dropped.
    logic w_unused;
    assign w_unused = ^{w_sel_addr[31:AW+2], w_sel_addr[1:0]};
    assign w_fault  = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_enter_resp = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_req) begin
                    if (WAIT_CYCLES == 0) begin
                        w_state_next = StResp;
                        w_enter_resp = 1'b1;
                        w_count_next = 4'd0;
                    end else begin
                        w_state_next = StWait;
                        w_count_next = 4'(WAIT_CYCLES);
                    end
                end
            end
            StWait: begin
                w_count_next = r_count - 4'd1;
                if (r_count <= 4'd1) begin
                    w_state_next = StResp;
                    w_enter_resp = 1'b1;
                    w_count_next = 4'd0;
                end
            end
            StResp: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // State, request latch and load-data register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_count    <= 4'd0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_read     <= 1'b0;
            r_write    <= 1'b0;
            r_err      <= 1'b0;
            r_ram_data <= 32'h0000_0000;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            if (r_state == StIdle && w_req) begin
                r_addr  <= address;
                r_wdata <= write_data;
                r_read  <= mem_read;
                r_write <= mem_write;
            end
            if (w_enter_resp) begin
                r_err <= w_fault;
                if (w_fault) begin
                    r_ram_data <= 32'hDEAD_BEEF;
                end else if (w_sel_read) begin
                    // Also covers read+write: the old word is returned.
                    r_ram_data <= r_mem[w_sel_idx];
                end
            end else if (r_state == StResp) begin
                r_err <= 1'b0;
            end
        end
    end

    // Store commits as RESP completes; a reset on that edge cancels it.
    always_ff @(posedge clk) begin
        if (!rst && r_state == StResp && r_write && !r_err) begin
            r_mem[w_resp_idx] <= r_wdata;
        end
    end

    assign ram_data = r_ram_data;
    assign ready    = (r_state == StResp);
    assign busy     = (r_state != StIdle);

`ifdef DMEM_RANGE_CHECK_EN
    assign err = r_err;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic [31:0] address, write_data;
    logic        a_rd, a_wr, b_rd, b_wr;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, a_busy, b_busy;
    logic        a_err, b_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Instance A: default configuration, two wait states.
    data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) u_dut_a (
        .clk        (clk),
        .rst        (rst_a),
        .address    (address),
        .write_data (write_data),
        .mem_read   (a_rd),
        .mem_write  (a_wr),
        .ram_data   (a_data),
        .ready      (a_ready),
        .busy       (a_busy)
`ifdef DMEM_RANGE_CHECK_EN
        ,
        .err        (a_err)
`endif
    );

    // Instance B: zero wait states.
    data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) u_dut_b (
        .clk        (clk),
        .rst        (rst_b),
        .address    (address),
        .write_data (write_data),
        .mem_read   (b_rd),
        .mem_write  (b_wr),
        .ram_data   (b_data),
        .ready      (b_ready),
        .busy       (b_busy)
`ifdef DMEM_RANGE_CHECK_EN
        ,
        .err        (b_err)
`endif
    );

`ifndef DMEM_RANGE_CHECK_EN
    assign a_err = 1'b0;
    assign b_err = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One complete transaction; request held until ready, then dropped.
    task automatic xact(input bit sel, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_data, input logic exp_err,
                        input string name);
        int  lat;
        int  exp_lat;
        bit  got;
        exp_lat = sel ? 1 : 3;
        @(negedge clk);
        address    = addr;
        write_data = wd;
        if (sel) begin b_rd = rd; b_wr = wr; end
        else     begin a_rd = rd; a_wr = wr; end
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 1) chk({name, " busy"}, 32'(sel ? b_busy : a_busy), 32'd1);
            got = sel ? b_ready : a_ready;
        end
        a_rd = 1'b0; a_wr = 1'b0; b_rd = 1'b0; b_wr = 1'b0;
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s timeout: no ready within %0d cycles, expected %0d", name, lat, exp_lat);
        end else begin
            chk({name, " latency"}, 32'(lat), 32'(exp_lat));
            chk({name, " data"}, sel ? b_data : a_data, exp_data);
`ifdef DMEM_RANGE_CHECK_EN
            chk({name, " err"}, 32'(sel ? b_err : a_err), 32'(exp_err));
`endif
            @(negedge clk);
            chk({name, " ready pulse"}, 32'(sel ? b_ready : a_ready), 32'd0);
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int first_pulse, second_pulse, ready_seen;

        vecs[0] = '{1'b0, 1'b1, 32'h10,  32'h1234_5678, 32'h0000_0000, "store 0x10"};
        vecs[1] = '{1'b1, 1'b0, 32'h10,  32'h0,         32'h1234_5678, "load 0x10"};
        vecs[2] = '{1'b0, 1'b1, 32'h20,  32'h0000_0001, 32'h1234_5678, "store 0x20"};
        vecs[3] = '{1'b1, 1'b1, 32'h20,  32'hAAAA_5555, 32'h0000_0001, "rd+wr 0x20"};
        vecs[4] = '{1'b1, 1'b0, 32'h20,  32'h0,         32'hAAAA_5555, "load 0x20"};
        vecs[5] = '{1'b0, 1'b1, 32'h3FC, 32'hCAFE_F00D, 32'hAAAA_5555, "store last"};
        vecs[6] = '{1'b1, 1'b0, 32'h3FC, 32'h0,         32'hCAFE_F00D, "load last"};
        vecs[7] = '{1'b1, 1'b0, 32'h0,   32'h0,         32'h0000_0000, "load 0x0"};
        vecs[8] = '{1'b0, 1'b1, 32'h8,   32'h0BAD_C0DE, 32'h0000_0000, "store 0x8"};
        vecs[9] = '{1'b1, 1'b0, 32'h8,   32'h0,         32'h0BAD_C0DE, "load 0x8"};

        rst_a = 1'b1; rst_b = 1'b1;
        a_rd = 1'b0; a_wr = 1'b0; b_rd = 1'b0; b_wr = 1'b0;
        address = 32'h0; write_data = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset a busy",  32'(a_busy),  32'd0);
        chk("reset a ready", 32'(a_ready), 32'd0);
        chk("reset a data",  a_data,       32'h0);
        chk("reset b busy",  32'(b_busy),  32'd0);
        chk("reset b data",  b_data,       32'h0);
        rst_a = 1'b0; rst_b = 1'b0;

        // Zero wait states
        xact(1'b1, 1'b1, 1'b0, 32'h0, 32'h0,         32'h0, 1'b0, "b load 0x0");
        xact(1'b1, 1'b0, 1'b1, 32'h4, 32'h0000_0005, 32'h0, 1'b0, "b store 0x4");
        xact(1'b1, 1'b1, 1'b0, 32'h4, 32'h0,         32'h5, 1'b0, "b load 0x4");

        // Table-driven sequence on the two-wait instance
        for (int i = 0; i < 10; i++) begin
            xact(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd,
                 vecs[i].exp, 1'b0, vecs[i].name);
        end

        // Back-to-back loads with the request held continuously
        @(negedge clk);
        address = 32'h10;
        a_rd = 1'b1;
        first_pulse = 0; second_pulse = 0; ready_seen = 0;
        for (int c = 1; c <= 30 && ready_seen < 2; c++) begin
            @(negedge clk);
            if (a_ready) begin
                ready_seen++;
                if (ready_seen == 1) first_pulse = c;
                else second_pulse = c;
            end
        end
        a_rd = 1'b0;
        chk("b2b first ready",  32'(first_pulse),  32'd3);
        chk("b2b second ready", 32'(second_pulse), 32'd7);
        chk("b2b data", a_data, 32'h1234_5678);
        @(negedge clk);

        // Reset during WAIT of a store
        @(negedge clk);
        address = 32'h8; write_data = 32'hFFFF_FFFF; a_wr = 1'b1;
        @(negedge clk);
        chk("abort busy in wait", 32'(a_busy), 32'd1);
        rst_a = 1'b1; a_wr = 1'b0;
        @(negedge clk);
        chk("abort busy", 32'(a_busy), 32'd0);
        chk("abort data", a_data,      32'h0);
        rst_a = 1'b0;
        ready_seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (a_ready) ready_seen++;
        end
        chk("abort no ready", 32'(ready_seen), 32'd0);
        xact(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 32'h0BAD_C0DE, 1'b0, "load after abort");

`ifdef DMEM_RANGE_CHECK_EN
        xact(1'b0, 1'b0, 1'b1, 32'h400, 32'h7777_7777, 32'hDEAD_BEEF, 1'b1, "store 0x400 fault");
        xact(1'b0, 1'b1, 1'b0, 32'h0,   32'h0,         32'h0,         1'b0, "word0 unchanged");
        xact(1'b0, 1'b1, 1'b0, 32'h12,  32'h0,         32'hDEAD_BEEF, 1'b1, "misaligned fault");
        xact(1'b0, 1'b1, 1'b0, 32'h3FC, 32'h0,         32'hCAFE_F00D, 1'b0, "last in range");
`else
        xact(1'b0, 1'b0, 1'b1, 32'h400, 32'h7777_7777, 32'h0BAD_C0DE, 1'b0, "store 0x400 wrap");
        xact(1'b0, 1'b1, 1'b0, 32'h0,   32'h0,         32'h7777_7777, 1'b0, "word0 wrapped");
        xact(1'b0, 1'b1, 1'b0, 32'h12,  32'h0,         32'h1234_5678, 1'b0, "byte offset ignored");
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
